// File: rtl/mac_learn_table.sv
`default_nettype none
// ============================================================================
// Module      : mac_learn_table
// Description : Forwarding decision stage. It learns the binding between a
//               source MAC and its ingress port, looks up the destination MAC
//               and returns an egress port mask. The table is fully
//               associative, uses round-robin replacement and tick-based aging.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_learn_table #(
  parameter int NUM_PORTS   = 4,
  parameter int TABLE_DEPTH = 8,
  parameter int AGE_MAX     = 3
) (
  input  logic                           switch_clk,
  input  logic                           switch_rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [47:0]                    req_dst_mac,
  input  logic [47:0]                    req_src_mac,
  input  logic [$clog2(NUM_PORTS)-1:0]   req_port,
  input  logic                           age_tick,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [NUM_PORTS-1:0]           resp_port_mask,
  output logic                           resp_hit,
  output logic [$clog2(TABLE_DEPTH):0]   num_entries
);

  localparam int         PW      = $clog2(NUM_PORTS);
  localparam int         IW      = $clog2(TABLE_DEPTH);
  localparam int         CW      = IW + 1;
  localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);
  // Bit 40 is the group bit: the LSB of the first byte on the wire.
  localparam int         MC_BIT  = 40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_LEARN  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Captured request header
  logic [47:0]          dst_q, src_q;
  logic [PW-1:0]        inport_q;

  // LOOKUP-time results, consumed in LEARN
  logic                 dst_hit_q;
  logic [PW-1:0]        dst_port_q;
  logic                 src_hit_q;
  logic [IW-1:0]        src_idx_q;

  // Table storage
  logic [TABLE_DEPTH-1:0] valid_q, valid_d;
  logic [47:0]            mac_q  [TABLE_DEPTH];
  logic [47:0]            mac_d  [TABLE_DEPTH];
  logic [PW-1:0]          port_q [TABLE_DEPTH];
  logic [PW-1:0]          port_d [TABLE_DEPTH];
  logic [7:0]             age_q  [TABLE_DEPTH];
  logic [7:0]             age_d  [TABLE_DEPTH];
  logic [IW-1:0]          rr_q, rr_d;

  // Response registers
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 hit_q, hit_d;
  logic [CW-1:0]        num_q, num_d;

  // Lookup / allocation wires
  logic                 w_dst_hit;
  logic [PW-1:0]        w_dst_port;
  logic                 w_src_hit;
  logic [IW-1:0]        w_src_idx;
  logic                 w_free_found;
  logic [IW-1:0]        w_free_idx;
  logic                 w_learn_en;
  logic [IW-1:0]        w_learn_idx;
  logic                 w_rr_adv;
  logic [NUM_PORTS-1:0] w_flood;
  logic [NUM_PORTS-1:0] w_onehot;

  // FSM state register
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_LEARN;
      S_LEARN:  state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the header on acceptance and the lookup results one cycle later
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      dst_q      <= '0;
      src_q      <= '0;
      inport_q   <= '0;
      dst_hit_q  <= 1'b0;
      dst_port_q <= '0;
      src_hit_q  <= 1'b0;
      src_idx_q  <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        dst_q    <= req_dst_mac;
        src_q    <= req_src_mac;
        inport_q <= req_port;
      end
      if (state_q == S_LOOKUP) begin
        dst_hit_q  <= w_dst_hit;
        dst_port_q <= w_dst_port;
        src_hit_q  <= w_src_hit;
        src_idx_q  <= w_src_idx;
      end
    end
  end

  // Parallel compare against all valid entries; lowest index wins on ties
  always_comb begin
    w_dst_hit    = 1'b0;
    w_dst_port   = '0;
    w_src_hit    = 1'b0;
    w_src_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && mac_q[i] == dst_q) begin
        w_dst_hit  = 1'b1;
        w_dst_port = port_q[i];
      end
      if (valid_q[i] && mac_q[i] == src_q) begin
        w_src_hit = 1'b1;
        w_src_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  // Learn target: refresh on hit, else first free slot, else round-robin victim.
  // The free slot is evaluated in LEARN so entries aged out meanwhile are reused.
  always_comb begin
    w_learn_en  = (state_q == S_LEARN) && !src_q[MC_BIT];
    w_learn_idx = src_hit_q ? src_idx_q : (w_free_found ? w_free_idx : rr_q);
    w_rr_adv    = w_learn_en && !src_hit_q && !w_free_found;
  end

  // Table next state: a learn write to an entry overrides its aging
  always_comb begin
    valid_d = valid_q;
    mac_d   = mac_q;
    port_d  = port_q;
    age_d   = age_q;
    rr_d    = rr_q;
    for (int e = 0; e < TABLE_DEPTH; e++) begin
      if (w_learn_en && w_learn_idx == IW'(e)) begin
        valid_d[e] = 1'b1;
        mac_d[e]   = src_q;
        port_d[e]  = inport_q;
        age_d[e]   = '0;
      end else if (age_tick && valid_q[e]) begin
        if (age_q[e] + 8'd1 >= AGE_LIM) begin
          valid_d[e] = 1'b0;
          age_d[e]   = '0;
        end else begin
          age_d[e] = age_q[e] + 8'd1;
        end
      end
    end
    if (w_rr_adv) rr_d = rr_q + IW'(1);
  end

  // Table storage registers
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      for (int e = 0; e < TABLE_DEPTH; e++) begin
        mac_q[e]  <= '0;
        port_q[e] <= '0;
        age_q[e]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      for (int e = 0; e < TABLE_DEPTH; e++) begin
        mac_q[e]  <= mac_d[e];
        port_q[e] <= port_d[e];
        age_q[e]  <= age_d[e];
      end
    end
  end

  // Forwarding decision from the LOOKUP-time results, held through RESP
  always_comb begin
    w_flood  = ~(NUM_PORTS'(1) << inport_q);
    w_onehot = NUM_PORTS'(1) << dst_port_q;
    mask_d   = mask_q;
    hit_d    = hit_q;
    if (state_q == S_LEARN) begin
      if (dst_q[MC_BIT]) begin
        mask_d = w_flood;
        hit_d  = 1'b0;
      end else if (dst_hit_q) begin
        mask_d = (dst_port_q == inport_q) ? '0 : w_onehot;
        hit_d  = 1'b1;
      end else begin
        mask_d = w_flood;
        hit_d  = 1'b0;
      end
    end
  end

  // Popcount of valid bits, registered one cycle behind the table
  always_comb begin
    num_d = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) num_d = num_d + CW'(valid_q[i]);
  end

  // Response and occupancy registers
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      mask_q <= '0;
      hit_q  <= 1'b0;
      num_q  <= '0;
    end else begin
      mask_q <= mask_d;
      hit_q  <= hit_d;
      num_q  <= num_d;
    end
  end

  assign resp_port_mask = mask_q;
  assign resp_hit       = hit_q;
  assign num_entries    = num_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_learn_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_learn_table
// Description : Directed bench for mac_learn_table with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_learn_table;

  localparam int NP = 4;
  localparam int TD = 8;

  localparam logic [47:0] MAC_A  = 48'h0011_2233_4400;
  localparam logic [47:0] MAC_B  = 48'h1020_3040_5000;
  localparam logic [47:0] MAC_C  = 48'h0011_2233_4477;
  localparam logic [47:0] MAC_X  = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_BC = 48'hffff_ffff_ffff;
  localparam logic [47:0] MAC_MC = 48'h0100_5e00_0001;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_dst_mac;
  logic [47:0] req_src_mac;
  logic [1:0]  req_port;
  logic        age_tick;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_port_mask;
  logic        resp_hit;
  logic [3:0]  num_entries;

  typedef struct packed {
    logic       hit;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mac_learn_table #(.NUM_PORTS(NP), .TABLE_DEPTH(TD), .AGE_MAX(3)) dut (
    .switch_clk     (clk),
    .switch_rst_n   (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dst_mac    (req_dst_mac),
    .req_src_mac    (req_src_mac),
    .req_port       (req_port),
    .age_tick       (age_tick),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_port_mask (resp_port_mask),
    .resp_hit       (resp_hit),
    .num_entries    (num_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    age_tick = 1'b1;
    @(negedge clk);
    age_tick = 1'b0;
  endtask

  task automatic chk_num(input string tag, input int exp);
    repeat (2) @(negedge clk);
    chk(tag, 64'(num_entries), 64'(exp));
  endtask

  // Issue one request, expect the given decision, check the 3-cycle latency.
  task automatic do_req(input string tag, input logic [47:0] dst, input logic [47:0] src,
                        input logic [1:0] port, input logic hit, input logic [3:0] mask);
    exp_t e;
    int   n;
    bit   ok;
    sb.push_back('{hit: hit, mask: mask});
    @(negedge clk);
    req_valid   = 1'b1;
    req_dst_mac = dst;
    req_src_mac = src;
    req_port    = port;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk({tag, "_accept_timeout"}, 64'(0), 64'(1));
      req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({tag, "_resp_timeout"}, 64'(0), 64'(1));
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(n), 64'(3));
    chk({tag, "_hit"}, 64'(resp_hit), 64'(e.hit));
    chk({tag, "_mask"}, 64'(resp_port_mask), 64'(e.mask));
    @(posedge clk);
    #1;
  endtask

  // Global watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit   ok;
    rst_n       = 1'b1;
    req_valid   = 1'b0;
    req_dst_mac = '0;
    req_src_mac = '0;
    req_port    = '0;
    age_tick    = 1'b0;
    resp_ready  = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_mask", 64'(resp_port_mask), 64'(0));
    chk("rst_hit", 64'(resp_hit), 64'(0));
    chk("rst_num", 64'(num_entries), 64'(0));

    // Learning and unicast / filter / flood decisions
    do_req("t1", MAC_B, MAC_A, 2'd0, 1'b0, 4'b1110);
    chk_num("t1_num", 1);
    do_req("t2a", MAC_A, MAC_B, 2'd2, 1'b1, 4'b0001);
    chk_num("t2a_num", 2);
    do_req("t2b", MAC_B, MAC_A, 2'd0, 1'b1, 4'b0100);
    do_req("t3a", MAC_A, MAC_A, 2'd0, 1'b1, 4'b0000);
    do_req("t3b", MAC_BC, MAC_MC, 2'd1, 1'b0, 4'b1101);
    chk_num("t3_num", 2);

    // Fill the table and exercise round-robin replacement
    do_reset();
    for (int i = 0; i < 9; i++)
      do_req("t4_fill", MAC_BC, {40'h00_1122_3344, 8'(i)}, 2'd3, 1'b0, 4'b0111);
    chk_num("t4_num_full", 8);
    do_req("t4_evicted", {40'h00_1122_3344, 8'h00}, MAC_MC, 2'd1, 1'b0, 4'b1101);
    do_req("t4_kept", {40'h00_1122_3344, 8'h01}, MAC_MC, 2'd1, 1'b1, 4'b1000);
    do_req("t4_new", {40'h00_1122_3344, 8'h08}, MAC_MC, 2'd1, 1'b1, 4'b1000);
    do_req("t4_fill9", MAC_BC, {40'h00_1122_3344, 8'h09}, 2'd3, 1'b0, 4'b0111);
    do_req("t4_rr_next", {40'h00_1122_3344, 8'h01}, MAC_MC, 2'd1, 1'b0, 4'b1101);
    do_req("t4_rr_new", {40'h00_1122_3344, 8'h09}, MAC_MC, 2'd0, 1'b1, 4'b1000);
    chk_num("t4_num_after", 8);

    // Aging out, and refresh between ticks
    do_reset();
    do_req("t5_learn", MAC_BC, MAC_X, 2'd1, 1'b0, 4'b1101);
    tick();
    tick();
    chk_num("t5_num_two_ticks", 1);
    tick();
    chk_num("t5_num_aged", 0);
    do_req("t5_relearn", MAC_BC, MAC_X, 2'd1, 1'b0, 4'b1101);
    tick();
    tick();
    do_req("t5_refresh", MAC_BC, MAC_X, 2'd1, 1'b0, 4'b1101);
    tick();
    chk_num("t5_num_survive", 1);
    do_req("t5_lookup", MAC_X, MAC_MC, 2'd0, 1'b1, 4'b0010);
    tick();
    chk_num("t5_num_age2", 1);
    tick();
    chk_num("t5_num_gone", 0);

    // Response backpressure
    do_reset();
    do_req("t6_learn", MAC_BC, MAC_A, 2'd0, 1'b0, 4'b1110);
    sb.push_back('{hit: 1'b1, mask: 4'b0001});
    @(negedge clk);
    resp_ready  = 1'b0;
    req_valid   = 1'b1;
    req_dst_mac = MAC_A;
    req_src_mac = MAC_C;
    req_port    = 2'd1;
    @(posedge clk);
    #1;
    req_dst_mac = MAC_BC;
    req_src_mac = MAC_B;
    req_port    = 2'd2;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    chk("t6_resp_seen", 64'(ok), 64'(1));
    e = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      chk("t6_hold_valid", 64'(resp_valid), 64'(1));
      chk("t6_hold_hit", 64'(resp_hit), 64'(e.hit));
      chk("t6_hold_mask", 64'(resp_port_mask), 64'(e.mask));
      chk("t6_hold_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b1;
    end
    chk("t6_no_extra_resp", 64'(ok), 64'(0));
    chk_num("t6_num", 2);

    // Reset during LOOKUP drops the request and clears the table
    @(negedge clk);
    req_valid   = 1'b1;
    req_dst_mac = MAC_A;
    req_src_mac = MAC_X;
    req_port    = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b1;
    end
    chk("t6_rst_no_resp", 64'(ok), 64'(0));
    chk("t6_rst_num", 64'(num_entries), 64'(0));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
